// File: rtl/hand_sorter.sv
// hand_sorter: sequential bubble sorter for packed card/hand vectors.
//
// Loads N elements of W bits in one cycle. It then runs one compare-and-swap per clock with a
// single comparator. The compare key is the unsigned field data[KEY_LSB +: KEY_W]. The order is
// ascending or descending and is chosen per request. Equal keys never swap, so the sort is stable.
// The sort stops early after a pass that makes no swap.
//
// Ports:
//   clk     in   1     system clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request pulse, sampled only while busy=0
//   desc    in   1     order select sampled with start (0 ascending, 1 descending)
//   din     in   N*W   input vector, element k at din[k*W +: W]
//   busy    out  1     high while sorting
//   done    out  1     one-cycle completion pulse
//   dout    out  N*W   sorted result, held until the next done
//   passes  out  8     passes used by the last sort, held until the next done
module hand_sorter #(
  parameter int unsigned N       = 17,
  parameter int unsigned W       = 8,
  parameter int unsigned KEY_LSB = 0,
  parameter int unsigned KEY_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           desc,
  input  logic [N*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] dout,
  output logic [7:0]     passes
);

  localparam int unsigned IW      = (N > 2) ? $clog2(N) : 1;
  localparam logic [7:0]  LastIdx = 8'(N - 2);

  typedef enum logic [0:0] {StIdle, StSort} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   data_q [N];
  logic [W-1:0]   data_d [N];
  logic [7:0]     i_q, i_d;
  logic [7:0]     p_q, p_d;
  logic           swapped_q, swapped_d;
  logic           desc_q, desc_d;
  logic           done_q, done_d;
  logic [N*W-1:0] dout_q, dout_d;
  logic [7:0]     passes_q, passes_d;

  logic [7:0]     i_plus;
  logic [IW-1:0]  idx_a, idx_b;
  logic [W-1:0]   elem_a, elem_b;
  logic [KEY_W-1:0] key_a, key_b;
  logic           do_swap;
  logic           end_of_pass;
  logic           last_pass;
  logic           pass_swapped;
  logic [N*W-1:0] sorted_packed;

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    i_d           = i_q;
    p_d           = p_q;
    swapped_d     = swapped_q;
    desc_d        = desc_q;
    done_d        = 1'b0;
    dout_d        = dout_q;
    passes_d      = passes_q;
    sorted_packed = '0;

    // Single comparator, always looking at the pair (i, i+1).
    i_plus       = i_q + 8'd1;
    idx_a        = i_q[IW-1:0];
    idx_b        = i_plus[IW-1:0];
    elem_a       = data_q[idx_a];
    elem_b       = data_q[idx_b];
    key_a        = elem_a[KEY_LSB +: KEY_W];
    key_b        = elem_b[KEY_LSB +: KEY_W];
    do_swap      = desc_q ? (key_a < key_b) : (key_a > key_b);
    // Each pass leaves one more element settled at the tail, so the pass shortens by one.
    end_of_pass  = (i_q == (LastIdx - p_q));
    last_pass    = (p_q == LastIdx);
    pass_swapped = swapped_q | do_swap;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int k = 0; k < int'(N); k++) begin
            data_d[k] = din[k*W +: W];
          end
          desc_d    = desc;
          i_d       = 8'd0;
          p_d       = 8'd0;
          swapped_d = 1'b0;
          state_d   = StSort;
        end
      end
      StSort: begin
        if (do_swap) begin
          data_d[idx_a] = elem_b;
          data_d[idx_b] = elem_a;
        end
        swapped_d = pass_swapped;
        // Build the packed result from the post-swap array so the final swap is included.
        for (int k = 0; k < int'(N); k++) begin
          sorted_packed[k*W +: W] = data_d[k];
        end
        if (end_of_pass) begin
          if (!pass_swapped || last_pass) begin
            dout_d   = sorted_packed;
            passes_d = p_q + 8'd1;
            done_d   = 1'b1;
            i_d      = 8'd0;
            p_d      = 8'd0;
            state_d  = StIdle;
          end else begin
            p_d       = p_q + 8'd1;
            i_d       = 8'd0;
            swapped_d = 1'b0;
          end
        end else begin
          i_d = i_plus;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      for (int k = 0; k < int'(N); k++) begin
        data_q[k] <= '0;
      end
      i_q       <= 8'd0;
      p_q       <= 8'd0;
      swapped_q <= 1'b0;
      desc_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      passes_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      i_q       <= i_d;
      p_q       <= p_d;
      swapped_q <= swapped_d;
      desc_q    <= desc_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      passes_q  <= passes_d;
    end
  end

  assign busy   = (state_q == StSort);
  assign done   = done_q;
  assign dout   = dout_q;
  assign passes = passes_q;

endmodule

// File: tb/tb_hand_sorter.sv
module tb_hand_sorter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (N=17, W=8, full 8-bit key)
  logic         start_a, desc_a, busy_a, done_a;
  logic [135:0] din_a, dout_a;
  logic [7:0]   passes_a;
  // Instance B: N=3, W=8, key = low nibble (stability)
  logic         start_b, desc_b, busy_b, done_b;
  logic [23:0]  din_b, dout_b;
  logic [7:0]   passes_b;
  // Instance C: N=2, W=4
  logic         start_c, desc_c, busy_c, done_c;
  logic [7:0]   din_c, dout_c;
  logic [7:0]   passes_c;

  hand_sorter u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .desc(desc_a), .din(din_a),
    .busy(busy_a), .done(done_a), .dout(dout_a), .passes(passes_a)
  );

  hand_sorter #(.N(3), .W(8), .KEY_LSB(0), .KEY_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .desc(desc_b), .din(din_b),
    .busy(busy_b), .done(done_b), .dout(dout_b), .passes(passes_b)
  );

  hand_sorter #(.N(2), .W(4), .KEY_LSB(0), .KEY_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .desc(desc_c), .din(din_c),
    .busy(busy_c), .done(done_c), .dout(dout_c), .passes(passes_c)
  );

  int           sel;
  logic         cur_busy, cur_done;
  logic [135:0] cur_dout;
  logic [7:0]   cur_passes;

  always_comb begin
    cur_busy   = busy_a;
    cur_done   = done_a;
    cur_dout   = dout_a;
    cur_passes = passes_a;
    if (sel == 1) begin
      cur_busy   = busy_b;
      cur_done   = done_b;
      cur_dout   = 136'(dout_b);
      cur_passes = passes_b;
    end else if (sel == 2) begin
      cur_busy   = busy_c;
      cur_done   = done_c;
      cur_dout   = 136'(dout_c);
      cur_passes = passes_c;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int s);
    return (s == 0) ? 17 : (s == 1) ? 3 : 2;
  endfunction
  function automatic int kw_of(input int s);
    return (s == 0) ? 8 : 4;
  endfunction
  function automatic int w_of(input int s);
    return (s == 2) ? 4 : 8;
  endfunction

  // Reference: stable sort by rank; passes from the largest leftward displacement
  // (bubble sort moves an element at most one place left per pass, plus one clean pass).
  task automatic model(input int s, input bit dsc, input int unsigned e[17],
                       output logic [135:0] ev, output int ep, output int ek);
    int n, w, dmax, rank, dj;
    int unsigned mask, ki, kj;
    n = n_of(s);
    w = w_of(s);
    mask = (32'd1 << kw_of(s)) - 1;
    ev = '0;
    dmax = 0;
    for (int j = 0; j < n; j++) begin
      kj = e[j] & mask;
      rank = 0;
      dj = 0;
      for (int i = 0; i < n; i++) begin
        ki = e[i] & mask;
        if (dsc ? (ki > kj) : (ki < kj)) rank++;
        else if (ki == kj && i < j) rank++;
        if (i < j && (dsc ? (ki < kj) : (ki > kj))) dj++;
      end
      ev |= 136'(e[j]) << (rank * w);
      if (dj > dmax) dmax = dj;
    end
    ep = (dmax + 1 < n - 1) ? dmax + 1 : n - 1;
    ek = 0;
    for (int p = 0; p < ep; p++) ek += n - 1 - p;
  endtask

  task automatic drive(input bit dsc, input int unsigned e[17]);
    if (sel == 0) begin
      din_a = '0;
      for (int k = 0; k < 17; k++) din_a[k*8 +: 8] = 8'(e[k]);
      desc_a = dsc; start_a = 1'b1;
    end else if (sel == 1) begin
      for (int k = 0; k < 3; k++) din_b[k*8 +: 8] = 8'(e[k]);
      desc_b = dsc; start_b = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) din_c[k*4 +: 4] = 4'(e[k]);
      desc_c = dsc; start_c = 1'b1;
    end
  endtask

  task automatic clear_start();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until done is seen (bounded).
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!cur_done && cyc < 400);
  endtask

  task automatic check_result(input string tag, input int cyc, input logic [135:0] ev,
                              input int ep, input int ek);
    chk({tag, "_done"}, 136'(cur_done), 136'(1));
    chk({tag, "_k"}, 136'(cyc), 136'(ek));
    chk({tag, "_passes"}, 136'(cur_passes), 136'(ep));
    chk({tag, "_dout"}, cur_dout, ev);
  endtask

  // now=1: drive immediately (used from inside the done cycle for back-to-back).
  task automatic sort_check(input string tag, input bit dsc, input int unsigned e[17],
                            input bit now);
    logic [135:0] ev;
    int ep, ek, cyc;
    model(sel, dsc, e, ev, ep, ek);
    if (!now) @(negedge clk);
    drive(dsc, e);
    @(posedge clk); #1;
    clear_start();
    chk({tag, "_busy"}, 136'(cur_busy), 136'(1));
    wait_done(0, cyc);
    check_result(tag, cyc, ev, ep, ek);
  endtask

  int unsigned e[17];
  int unsigned e2[17];
  logic [135:0] ev;
  int ep, ek, cyc;

  initial begin
    rst_n = 1'b0;
    sel = 0;
    clear_start();
    desc_a = 0; desc_b = 0; desc_c = 0;
    din_a = '0; din_b = '0; din_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 136'(busy_a), 136'(0));
    chk("rst_done", 136'(done_a), 136'(0));
    chk("rst_dout", dout_a, 136'(0));
    chk("rst_passes", 136'(passes_a), 136'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending 0..16: already ordered.
    for (int k = 0; k < 17; k++) e[k] = k;
    sort_check("asc_sorted", 1'b0, e, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", 136'(done_a), 136'(0));
    chk("idle_after", 136'(busy_a), 136'(0));

    // Reverse, worst case.
    for (int k = 0; k < 17; k++) e[k] = 16 - k;
    sort_check("asc_reverse", 1'b0, e, 1'b0);

    // Descending on ascending input, then on descending input.
    for (int k = 0; k < 17; k++) e[k] = k;
    sort_check("desc_rev", 1'b1, e, 1'b0);
    for (int k = 0; k < 17; k++) e[k] = 16 - k;
    sort_check("desc_sorted", 1'b1, e, 1'b0);

    // Back-to-back: second start lands in the done cycle.
    for (int k = 0; k < 17; k++) e[k] = $urandom_range(0, 255);
    sort_check("b2b_first", 1'b0, e, 1'b0);
    for (int k = 0; k < 17; k++) e[k] = $urandom_range(0, 255);
    sort_check("b2b_second", 1'b1, e, 1'b1);

    // start/din/desc changes while busy are ignored.
    for (int k = 0; k < 17; k++) e[k] = 16 - k;
    for (int k = 0; k < 17; k++) e2[k] = $urandom_range(0, 255);
    model(0, 1'b0, e, ev, ep, ek);
    @(negedge clk);
    drive(1'b0, e);
    @(posedge clk); #1;
    drive(1'b1, e2);
    @(posedge clk); #1;
    clear_start();
    wait_done(1, cyc);
    check_result("ignore_busy", cyc, ev, ep, ek);

    // Reset at compare 50 of a reverse-sorted input.
    for (int k = 0; k < 17; k++) e[k] = 16 - k;
    @(negedge clk);
    drive(1'b0, e);
    @(posedge clk); #1;
    clear_start();
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 136'(busy_a), 136'(0));
    chk("abort_done", 136'(done_a), 136'(0));
    chk("abort_dout", dout_a, 136'(0));
    chk("abort_passes", 136'(passes_a), 136'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 136'(done_a), 136'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) e[k] = $urandom_range(0, 255);
    sort_check("after_abort", 1'b0, e, 1'b0);

    // Randomized, with small value ranges to force equal keys.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 17; k++) e[k] = (t % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      sort_check("rand_a", 1'($urandom_range(0, 1)), e, 1'b0);
    end

    // Stability build.
    sel = 1;
    e = '{default: 0};
    e[0] = 'h31; e[1] = 'h12; e[2] = 'h21;
    sort_check("stable", 1'b0, e, 1'b0);
    e[0] = 'h05; e[1] = 'hA5; e[2] = 'h35;
    sort_check("all_equal", 1'b0, e, 1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 3; k++) e[k] = $urandom_range(0, 255);
      sort_check("rand_b", 1'($urandom_range(0, 1)), e, 1'b0);
    end

    // N=2 build.
    sel = 2;
    e = '{default: 0};
    e[0] = 'h3; e[1] = 'h1;
    sort_check("n2", 1'b0, e, 1'b0);
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 2; k++) e[k] = $urandom_range(0, 15);
      sort_check("rand_c", 1'($urandom_range(0, 1)), e, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
